// File: rtl/imm_decode_stage.sv
// imm_decode_stage: RV32I/RV64I immediate decode feeding a registered valid/ready
// output with a 2-entry (main + skid) buffer, so in_ready never depends combinationally on out_ready.
module imm_decode_stage #(
    parameter int XLEN  = 64,
    parameter int TAG_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_fmt,
    output logic             out_illegal,
    output logic [TAG_W-1:0] out_tag,
    output logic [1:0]       occupancy
);
    localparam logic [2:0] F_NONE = 3'd0, F_I = 3'd1, F_S = 3'd2, F_B = 3'd3, F_U = 3'd4, F_J = 3'd5;

    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;

    typedef struct packed {
        logic [XLEN-1:0]  imm;
        logic [2:0]       fmt;
        logic             ill;
        logic [TAG_W-1:0] tag;
    } entry_t;

    state_t          state_q, state_d;
    entry_t          main_q, main_d, skid_q, skid_d, dec;
    logic            in_ready_q, shift, acc, pop;
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j, shamt;

    assign imm_i = XLEN'($signed(in_instr[31:20]));
    assign imm_s = XLEN'($signed({in_instr[31:25], in_instr[11:7]}));
    assign imm_b = XLEN'($signed({in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0}));
    assign imm_u = XLEN'($signed({in_instr[31:12], 12'b0}));
    assign imm_j = XLEN'($signed({in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0}));
    // funct3 001/101 are the shifts; funct6/funct7 above shamt must not leak into imm
    assign shift = in_instr[13:12] == 2'b01;
    assign shamt = XLEN == 64 ? XLEN'(in_instr[25:20]) : XLEN'(in_instr[24:20]);

    always_comb begin
        dec     = '0;
        dec.tag = in_tag;
        dec.ill = 1'b1;
        case (in_instr[6:0])
            7'b0000011, 7'b0001111, 7'b1100111, 7'b1110011: dec = '{imm_i, F_I, 1'b0, in_tag};
            7'b0010011: dec = '{shift ? shamt : imm_i, F_I, 1'b0, in_tag};
            7'b0011011: if (XLEN == 64) dec = '{shift ? XLEN'(in_instr[24:20]) : imm_i, F_I, 1'b0, in_tag};
            7'b0100011: dec = '{imm_s, F_S, 1'b0, in_tag};
            7'b1100011: dec = '{imm_b, F_B, 1'b0, in_tag};
            7'b0110111, 7'b0010111: dec = '{imm_u, F_U, 1'b0, in_tag};
            7'b1101111: dec = '{imm_j, F_J, 1'b0, in_tag};
            default: dec.fmt = F_NONE;
        endcase
    end

    assign acc = in_valid && in_ready_q;
    assign pop = out_valid && out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: if (acc) begin
                    main_d  = dec;
                    state_d = ONE;
                end
                ONE: if (acc && pop) begin
                    main_d = dec;
                end else if (acc) begin
                    skid_d  = dec;
                    state_d = FULL;
                end else if (pop) begin
                    state_d = EMPTY;
                end
                FULL: if (pop) begin
                    main_d  = skid_q;
                    state_d = ONE;
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= EMPTY;
            main_q     <= '0;
            skid_q     <= '0;
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
            in_ready_q <= state_d != FULL;
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = state_q != EMPTY;
    assign out_imm     = main_q.imm;
    assign out_fmt     = main_q.fmt;
    assign out_illegal = main_q.ill;
    assign out_tag     = main_q.tag;
    assign occupancy   = state_q;
endmodule

// File: tb/tb_imm_decode_stage.sv
// tb_imm_decode_stage: scoreboard bench driving XLEN=64 and XLEN=32 instances in lockstep
// with directed instructions, backpressure, flush and mid-run reset.
module tb_imm_decode_stage;
    logic        clk = 1'b0;
    logic        rst_n, flush, in_valid, out_ready;
    logic [31:0] in_instr;
    logic [7:0]  in_tag;
    logic        in_ready, out_valid, out_illegal;
    logic [63:0] out_imm;
    logic [2:0]  out_fmt;
    logic [7:0]  out_tag;
    logic [1:0]  occupancy;
    logic        in_ready32, out_valid32, out_illegal32;
    logic [31:0] out_imm32;
    logic [2:0]  out_fmt32;
    logic [7:0]  out_tag32;
    logic [1:0]  occupancy32;

    typedef struct {
        logic [31:0] ins;
        logic [63:0] i64;
        logic [2:0]  f64;
        logic        l64;
        logic [31:0] i32;
        logic [2:0]  f32;
        logic        l32;
    } vec_t;

    typedef struct {
        logic [63:0] imm;
        logic [2:0]  fmt;
        logic        ill;
        logic [7:0]  tag;
    } exp_t;

    vec_t vec[$];
    exp_t q64[$], q32[$];
    exp_t pe, e64, e32;
    int   cur = 0;
    int   checks = 0;
    int   errors = 0;

    imm_decode_stage #(.XLEN(64), .TAG_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
        .out_imm(out_imm), .out_fmt(out_fmt), .out_illegal(out_illegal), .out_tag(out_tag),
        .occupancy(occupancy)
    );

    imm_decode_stage #(.XLEN(32), .TAG_W(8)) dut32 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready32),
        .in_instr(in_instr), .in_tag(in_tag), .out_valid(out_valid32), .out_ready(out_ready),
        .out_imm(out_imm32), .out_fmt(out_fmt32), .out_illegal(out_illegal32), .out_tag(out_tag32),
        .occupancy(occupancy32)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic [31:0] ins, input logic [63:0] i64, input logic [2:0] f64,
                       input logic l64, input logic [31:0] i32, input logic [2:0] f32, input logic l32);
        vec_t v;
        v = '{ins, i64, f64, l64, i32, f32, l32};
        vec.push_back(v);
    endtask

    task automatic offer(input int idx, input logic [7:0] tg);
        int n = 0;
        cur = idx;
        in_valid = 1'b1;
        in_instr = vec[idx].ins;
        in_tag = tg;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 50) chk("offer_timeout", 64'd1, 64'd0);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    always @(posedge clk) begin
        if (!rst_n || flush) begin
            q64.delete();
            q32.delete();
        end else begin
            if (in_valid && in_ready) begin
                pe = '{vec[cur].i64, vec[cur].f64, vec[cur].l64, in_tag};
                q64.push_back(pe);
            end
            if (in_valid && in_ready32) begin
                pe = '{{32'd0, vec[cur].i32}, vec[cur].f32, vec[cur].l32, in_tag};
                q32.push_back(pe);
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && !flush && out_ready) begin
            if (out_valid) begin
                if (q64.size() == 0) chk("unexpected64", {56'd0, out_tag}, 64'hFFFF);
                else begin
                    e64 = q64.pop_front();
                    chk("imm64", out_imm, e64.imm);
                    chk("fmt64", {61'd0, out_fmt}, {61'd0, e64.fmt});
                    chk("ill64", {63'd0, out_illegal}, {63'd0, e64.ill});
                    chk("tag64", {56'd0, out_tag}, {56'd0, e64.tag});
                end
            end
            if (out_valid32) begin
                if (q32.size() == 0) chk("unexpected32", {56'd0, out_tag32}, 64'hFFFF);
                else begin
                    e32 = q32.pop_front();
                    chk("imm32", {32'd0, out_imm32}, e32.imm);
                    chk("fmt32", {61'd0, out_fmt32}, {61'd0, e32.fmt});
                    chk("ill32", {63'd0, out_illegal32}, {63'd0, e32.ill});
                    chk("tag32", {56'd0, out_tag32}, {56'd0, e32.tag});
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        add(32'hFFF00093, 64'hFFFFFFFFFFFFFFFF, 3'd1, 1'b0, 32'hFFFFFFFF, 3'd1, 1'b0);
        add(32'hFE000EE3, 64'hFFFFFFFFFFFFFFFC, 3'd3, 1'b0, 32'hFFFFFFFC, 3'd3, 1'b0);
        add(32'h800000B7, 64'hFFFFFFFF80000000, 3'd4, 1'b0, 32'h80000000, 3'd4, 1'b0);
        add(32'h0010006F, 64'h0000000000000800, 3'd5, 1'b0, 32'h00000800, 3'd5, 1'b0);
        add(32'h03F09093, 64'd63, 3'd1, 1'b0, 32'd31, 3'd1, 1'b0);
        add(32'h4010D093, 64'd1, 3'd1, 1'b0, 32'd1, 3'd1, 1'b0);
        add(32'h0000007F, 64'd0, 3'd0, 1'b1, 32'd0, 3'd0, 1'b1);
        add(32'h0010809B, 64'd1, 3'd1, 1'b0, 32'd0, 3'd0, 1'b1);
        add(32'h4030D09B, 64'd3, 3'd1, 1'b0, 32'd0, 3'd0, 1'b1);
        add(32'hFE20AC23, 64'hFFFFFFFFFFFFFFF8, 3'd2, 1'b0, 32'hFFFFFFF8, 3'd2, 1'b0);
        add(32'h7FF12083, 64'h7FF, 3'd1, 1'b0, 32'h7FF, 3'd1, 1'b0);
        add(32'h00000010, 64'd0, 3'd0, 1'b1, 32'd0, 3'd0, 1'b1);
        add(32'h00008067, 64'd0, 3'd1, 1'b0, 32'd0, 3'd1, 1'b0);
        add(32'h00001097, 64'h1000, 3'd4, 1'b0, 32'h1000, 3'd4, 1'b0);
        add(32'h00000073, 64'd0, 3'd1, 1'b0, 32'd0, 3'd1, 1'b0);
        add(32'h0FF0000F, 64'hFF, 3'd1, 1'b0, 32'hFF, 3'd1, 1'b0);
        add(32'h8000006F, 64'hFFFFFFFFFFF00000, 3'd5, 1'b0, 32'hFFF00000, 3'd5, 1'b0);
        add(32'h000000E3, 64'h800, 3'd3, 1'b0, 32'h800, 3'd3, 1'b0);

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_instr = '0; in_tag = '0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_occupancy", {62'd0, occupancy}, 64'd0);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
        chk("rst_imm", out_imm, 64'd0);
        chk("rst_fmt_ill_tag", {52'd0, out_fmt, out_illegal, out_tag}, 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("ready_after_rst", {63'd0, in_ready}, 64'd1);

        offer(0, 8'h10);
        chk("latency_valid", {63'd0, out_valid}, 64'd1);
        for (int i = 1; i < vec.size(); i++) begin
            offer(i, 8'h10 + 8'(i));
            chk("stream_occ", {62'd0, occupancy}, 64'd1);
        end
        repeat (2) @(posedge clk);
        #1;
        chk("drained", {61'd0, out_valid, occupancy}, 64'd0);

        out_ready = 1'b0;
        offer(0, 8'd1);
        offer(1, 8'd2);
        chk("bp_occ_full", {62'd0, occupancy}, 64'd2);
        chk("bp_ready_low", {63'd0, in_ready}, 64'd0);
        cur = 2; in_valid = 1'b1; in_instr = vec[2].ins; in_tag = 8'd3;
        repeat (3) begin
            @(posedge clk); #1;
            chk("bp_hold_occ", {62'd0, occupancy}, 64'd2);
            chk("bp_hold_ready", {63'd0, in_ready}, 64'd0);
            chk("bp_hold_tag", {56'd0, out_tag}, 64'd1);
            chk("bp_hold_imm", out_imm, vec[0].i64);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_first", {55'd0, out_valid, out_tag}, {55'd0, 1'b1, 8'd1});
        @(posedge clk); #1;
        @(negedge clk);
        chk("bp_second", {55'd0, out_valid, out_tag}, {55'd0, 1'b1, 8'd2});
        chk("bp_ready_back", {63'd0, in_ready}, 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("bp_third", {55'd0, out_valid, out_tag}, {55'd0, 1'b1, 8'd3});
        @(posedge clk); #1;
        chk("bp_empty", {63'd0, out_valid}, 64'd0);

        out_ready = 1'b0;
        offer(3, 8'd4);
        offer(4, 8'd5);
        chk("fl_occ_full", {62'd0, occupancy}, 64'd2);
        cur = 5; in_valid = 1'b1; in_instr = vec[5].ins; in_tag = 8'h55; flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        chk("fl_valid_occ", {61'd0, out_valid, occupancy}, 64'd0);
        chk("fl_ready", {63'd0, in_ready}, 64'd1);
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("fl_nothing", {63'd0, out_valid}, 64'd0);

        out_ready = 1'b0;
        offer(6, 8'd6);
        offer(7, 8'd7);
        chk("rs_occ_full", {62'd0, occupancy}, 64'd2);
        cur = 8; in_valid = 1'b1; in_instr = vec[8].ins; in_tag = 8'h66; rst_n = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("rs_valid_occ", {61'd0, out_valid, occupancy}, 64'd0);
        chk("rs_ready_low", {63'd0, in_ready}, 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rs_ready_up", {63'd0, in_ready}, 64'd1);
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rs_nothing", {63'd0, out_valid}, 64'd0);

        offer(9, 8'h20);
        offer(16, 8'h21);
        repeat (3) @(posedge clk);
        #1;
        chk("q64_empty", 64'(q64.size()), 64'd0);
        chk("q32_empty", 64'(q32.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
